// File: rtl/ifft_pkg.sv
// ============================================================================
//  Module      : ifft_pkg
//  Description : Shared state encoding, bit-reverse helper and twiddle
//                constant generation for the streaming IFFT.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifft_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    localparam real c_PI = 3.14159265358979323846;

    function automatic int unsigned bit_rev(input int unsigned x, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r = (r << 1) | ((x >> i) & 1);
        end
        return r;
    endfunction

    // cos/sin(2*pi*idx/n) by Taylor series so it folds at elaboration, rounded to Q2.(tw-2)
    function automatic int tw_val(input int idx, input int n, input int tw, input bit want_im);
        real x;
        real term;
        real sum;
        real scaled;
        x    = 2.0 * c_PI * real'(idx) / real'(n);
        term = want_im ? x : 1.0;
        sum  = term;
        for (int k = 1; k <= 20; k++) begin
            if (want_im) term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            else         term = -term * x * x / (real'(2 * k - 1) * real'(2 * k));
            sum = sum + term;
        end
        scaled = sum * real'(1 << (tw - 2));
        if (scaled >= 0.0) return $rtoi(scaled + 0.5);
        else               return -$rtoi(0.5 - scaled);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifft_bfly.sv
// ============================================================================
//  Module      : ifft_bfly
//  Description : Combinational radix-2 DIT butterfly with 1/2 scaling,
//                rounding and saturation to W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifft_bfly #(
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic signed [W-1:0]  a_re,
    input  logic signed [W-1:0]  a_im,
    input  logic signed [W-1:0]  b_re,
    input  logic signed [W-1:0]  b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    output logic signed [W-1:0]  x_re,
    output logic signed [W-1:0]  x_im,
    output logic signed [W-1:0]  y_re,
    output logic signed [W-1:0]  y_im
);

    localparam int c_PW = W + TW + 2;
    localparam logic signed [c_PW-1:0] c_RND = c_PW'(1) <<< (TW - 2);
    localparam logic signed [c_PW-1:0] c_MAX = c_PW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [c_PW-1:0] c_MIN = -c_MAX - c_PW'(1);

    logic signed [W+TW-1:0] w_rr, w_ii, w_ri, w_ir;
    logic signed [c_PW-1:0] w_p_re, w_p_im, w_a_re, w_a_im;
    logic signed [c_PW-1:0] w_s0_re, w_s0_im, w_s1_re, w_s1_im;

    function automatic logic signed [W-1:0] sat(input logic signed [c_PW-1:0] v);
        if (v > c_MAX)      return {1'b0, {(W-1){1'b1}}};
        else if (v < c_MIN) return {1'b1, {(W-1){1'b0}}};
        else                return v[W-1:0];
    endfunction

    assign w_rr = b_re * w_re;
    assign w_ii = b_im * w_im;
    assign w_ri = b_re * w_im;
    assign w_ir = b_im * w_re;

    assign w_p_re = c_PW'(w_rr) - c_PW'(w_ii);
    assign w_p_im = c_PW'(w_ri) + c_PW'(w_ir);
    assign w_a_re = c_PW'(a_re) <<< (TW - 2);
    assign w_a_im = c_PW'(a_im) <<< (TW - 2);

    assign w_s0_re = (w_a_re + w_p_re + c_RND) >>> (TW - 1);
    assign w_s0_im = (w_a_im + w_p_im + c_RND) >>> (TW - 1);
    assign w_s1_re = (w_a_re - w_p_re + c_RND) >>> (TW - 1);
    assign w_s1_im = (w_a_im - w_p_im + c_RND) >>> (TW - 1);

    assign x_re = sat(w_s0_re);
    assign x_im = sat(w_s0_im);
    assign y_re = sat(w_s1_re);
    assign y_im = sat(w_s1_im);

endmodule

`default_nettype wire

// File: rtl/ifft_stream.sv
// ============================================================================
//  Module      : ifft_stream
//  Description : Streaming N-point IFFT: load in bit-reversed order, run an
//                in-place radix-2 DIT engine one butterfly per cycle, unload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifft_stream
    import ifft_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 16,
    parameter int TW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last,
    output logic                busy
);

    localparam int c_LOG2N = $clog2(N);
    localparam int c_SW    = (c_LOG2N > 1) ? $clog2(c_LOG2N) : 1;
    localparam int c_BW    = c_LOG2N - 1;

    state_t r_state, w_state_nxt;

    logic [c_LOG2N-1:0] r_load_cnt, r_out_cnt;
    logic [c_SW-1:0]    r_stage;
    logic [c_BW-1:0]    r_bfly;

    logic signed [W-1:0] r_re [N];
    logic signed [W-1:0] r_im [N];

    logic signed [TW-1:0] w_tw_re_tab [N/2];
    logic signed [TW-1:0] w_tw_im_tab [N/2];

    logic [c_LOG2N-1:0] w_load_addr, w_b, w_h, w_j, w_top, w_bot;
    logic [c_BW-1:0]    w_tw_idx;
    logic               w_last_bfly, w_in_fire, w_out_fire;
    logic signed [W-1:0] w_x_re, w_x_im, w_y_re, w_y_im;

    for (genvar g = 0; g < N/2; g++) begin : g_twiddle
        localparam int c_RE = tw_val(g, N, TW, 1'b0);
        localparam int c_IM = tw_val(g, N, TW, 1'b1);
        assign w_tw_re_tab[g] = TW'(c_RE);
        assign w_tw_im_tab[g] = TW'(c_IM);
    end

    assign w_load_addr = c_LOG2N'(bit_rev(32'(r_load_cnt), c_LOG2N));

    // top = (b>>s)*2h + j is b with its low s bits cleared, doubled, plus j
    assign w_b      = {1'b0, r_bfly};
    assign w_h      = c_LOG2N'(1) << r_stage;
    assign w_j      = w_b & (w_h - 1'b1);
    assign w_top    = ((w_b & ~(w_h - 1'b1)) << 1) | w_j;
    assign w_bot    = w_top | w_h;
    assign w_tw_idx = c_BW'(w_j << (c_LOG2N - 1 - int'(r_stage)));

    assign w_last_bfly = (r_stage == c_SW'(c_LOG2N - 1)) && (r_bfly == {c_BW{1'b1}});
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = out_valid && out_ready;

    ifft_bfly #(.W(W), .TW(TW)) u_bfly (
        .a_re (r_re[w_top]),
        .a_im (r_im[w_top]),
        .b_re (r_re[w_bot]),
        .b_im (r_im[w_bot]),
        .w_re (w_tw_re_tab[w_tw_idx]),
        .w_im (w_tw_im_tab[w_tw_idx]),
        .x_re (w_x_re),
        .x_im (w_x_im),
        .y_re (w_y_re),
        .y_im (w_y_im)
    );

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_re[w_load_addr] <= in_re;
            r_im[w_load_addr] <= in_im;
        end else if (r_state == ST_COMPUTE) begin
            r_re[w_top] <= w_x_re;
            r_im[w_top] <= w_x_im;
            r_re[w_bot] <= w_y_re;
            r_im[w_bot] <= w_y_im;
        end
    end

    // Counters are powers of two wide, so they wrap back to 0 on their own
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_LOAD;
            r_load_cnt <= '0;
            r_stage    <= '0;
            r_bfly     <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) r_load_cnt <= r_load_cnt + 1'b1;
            if (r_state == ST_COMPUTE) begin
                r_bfly <= r_bfly + 1'b1;
                if (r_bfly == {c_BW{1'b1}}) r_stage <= w_last_bfly ? '0 : r_stage + 1'b1;
            end
            if (w_out_fire) r_out_cnt <= r_out_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        busy        = 1'b0;
        out_re      = '0;
        out_im      = '0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_load_cnt == {c_LOG2N{1'b1}})) w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                busy = 1'b1;
                if (w_last_bfly) w_state_nxt = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_re    = r_re[r_out_cnt];
                out_im    = r_im[r_out_cnt];
                out_last  = (r_out_cnt == {c_LOG2N{1'b1}});
                if (out_ready && out_last) w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ifft_stream.sv
// ============================================================================
//  Module      : tb_ifft_stream
//  Description : Self-checking bench for ifft_stream (N=8) against a
//                floating-point inverse DFT reference held in a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifft_stream;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int TW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_re, in_im;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_re, out_im;
    logic                out_last;
    logic                busy;

    typedef struct {
        int re;
        int im;
        int last;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   bp_arm = 1'b0;
    bit   bp_done = 1'b0;
    int   bp_stalls = 0;
    int   hs_in_frame = 0;
    int   fr[8];
    int   fi[8];

    always #5 clk = ~clk;

    ifft_stream #(.N(N), .W(W), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        int d;
        n_cmp++;
        d = (obs > exp) ? obs - exp : exp - obs;
        if (d > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(0.5 - v);
    endfunction

    task automatic push_frame(input int xr[8], input int xi[8], input int tol);
        real sr, si, ang;
        exp_t e;
        for (int n = 0; n < N; n++) begin
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < N; k++) begin
                ang = 2.0 * 3.14159265358979323846 * real'(k * n) / real'(N);
                sr = sr + real'(xr[k]) * $cos(ang) - real'(xi[k]) * $sin(ang);
                si = si + real'(xr[k]) * $sin(ang) + real'(xi[k]) * $cos(ang);
            end
            e.re   = rnd(sr / real'(N));
            e.im   = rnd(si / real'(N));
            e.last = (n == N - 1) ? 1 : 0;
            e.tol  = tol;
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input int xr[8], input int xi[8], input bit keep);
        int g;
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_re    = W'(xr[i]);
            in_im    = W'(xi[i]);
            g = 0;
            while (!in_ready && g < 400) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 400) chk("in_ready_timeout", g, 0, 0);
            @(posedge clk); #1;
        end
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        int e;
        e = 0;
        while (!out_valid && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (e == 6) begin
                chk({tag, "_busy_mid"}, busy, 1, 0);
                chk({tag, "_ovalid_mid"}, out_valid, 0, 0);
                chk({tag, "_ore_mid"}, out_re, 0, 0);
            end
        end
        chk({tag, "_latency"}, e, 12, 0);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (sb.size() > 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        chk({tag, "_drain"}, sb.size(), 0, 0);
        @(posedge clk); #1;
    endtask

    // Output monitor and out_ready driver share one process so stalls line up with samples
    initial begin
        int   stall_cnt;
        bit   last_seen;
        exp_t e;
        stall_cnt = 0;
        last_seen = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (last_seen) begin
                chk("in_ready_after_last", in_ready, 1, 0);
                last_seen = 1'b0;
            end
            out_ready = (stall_cnt > 0) ? 1'b0 : 1'b1;
            if (stall_cnt > 0) stall_cnt--;
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("sb_empty_on_output", int'(sb.size() == 0), 0, 0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_re", out_re, e.re, e.tol);
                    chk("out_im", out_im, e.im, e.tol);
                    chk("out_last", out_last, e.last, 0);
                end
                hs_in_frame++;
                if (out_last) begin
                    hs_in_frame = 0;
                    last_seen   = 1'b1;
                end
                if (bp_arm && !bp_done && hs_in_frame == 3) begin
                    bp_done   = 1'b1;
                    stall_cnt = 5;
                end
            end else if (out_valid) begin
                bp_stalls++;
                if (sb.size() > 0) begin
                    chk("stall_re", out_re, sb[0].re, sb[0].tol);
                    chk("stall_im", out_im, sb[0].im, sb[0].tol);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_re    = '0;
        in_im    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1, 0);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_busy", busy, 0, 0);
        chk("rst_out_last", out_last, 0, 0);
        chk("rst_out_re", out_re, 0, 0);
        chk("rst_out_im", out_im, 0, 0);
        rst = 1'b0;

        fr = '{1024, 0, 0, 0, 0, 0, 0, 0};
        fi = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_frame(fr, fi, 0);
        send_frame(fr, fi, 1'b0);
        check_latency("impulse");
        drain("impulse");

        fr = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
        push_frame(fr, fi, 1);
        send_frame(fr, fi, 1'b0);
        drain("dc");

        fr = '{0, 1024, 0, 0, 0, 0, 0, 0};
        push_frame(fr, fi, 1);
        send_frame(fr, fi, 1'b0);
        drain("tone");

        fr = '{0, 0, 300, 0, 0, -512, 0, 0};
        fi = '{0, 0, -200, 0, 0, 100, 0, 0};
        bp_arm = 1'b1;
        push_frame(fr, fi, 2);
        send_frame(fr, fi, 1'b0);
        drain("bp");
        chk("bp_stall_cycles", bp_stalls, 5, 0);

        fr = '{1024, 0, 0, 0, 0, 0, 0, 0};
        fi = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(fr, fi, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1, 0);
        chk("midrst_busy", busy, 0, 0);
        chk("midrst_out_valid", out_valid, 0, 0);
        rst = 1'b0;
        push_frame(fr, fi, 0);
        send_frame(fr, fi, 1'b0);
        check_latency("post_rst");
        drain("post_rst");

        fr = '{100, -50, 0, 200, 0, 0, 0, 400};
        fi = '{0, 75, 0, 0, -300, 0, 0, 0};
        push_frame(fr, fi, 2);
        send_frame(fr, fi, 1'b1);
        fr = '{1024, 0, 0, 0, 0, 0, 0, 0};
        fi = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_frame(fr, fi, 0);
        send_frame(fr, fi, 1'b0);
        check_latency("b2b");
        drain("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifft_stream.md
IFFT_STREAM -- requirements
Module: ifft_stream

Interface
REQ-001 Parameter N, default 8: frame length in complex samples; power of two, 4..1024.
REQ-002 Parameter W, default 16: signed width of each real and imaginary data component.
REQ-003 Parameter TW, default 16: signed twiddle width, format Q2.(TW-2), so +1.0 = 2^(TW-2).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input sample present.
REQ-007 in_ready  out  1  block accepts an input sample.
REQ-008 in_re, in_im  in  W each  signed spectrum bin X[k]; bins arrive in natural order k = 0..N-1.
REQ-009 out_valid  out  1  output sample present.
REQ-010 out_ready  in  1  downstream accepts the output sample.
REQ-011 out_re, out_im  out  W each  signed time sample x[n]; samples leave in natural order n = 0..N-1.
REQ-012 out_last  out  1  high with sample n = N-1.
REQ-013 busy  out  1  high in COMPUTE and UNLOAD.

Function
REQ-014 The block SHALL compute x[n] = (1/N)·Σ X[k]·e^(+j2πkn/N) using an iterative in-place radix-2 decimation-in-time engine over an N-entry complex register array.
REQ-015 The state machine SHALL have three states, with only the following transitions:
- LOAD -> COMPUTE on acceptance of sample N-1.
- COMPUTE -> UNLOAD after the last butterfly.
- UNLOAD -> LOAD on the out_ready handshake of sample N-1.
REQ-016 in_ready SHALL be 1 only in LOAD; a sample is accepted on a cycle with in_valid && in_ready and is written to the bit-reversed address of the input index.
REQ-017 COMPUTE SHALL perform exactly one butterfly per cycle, with stage s = 0..log2(N)-1 and butterfly index b = 0..N/2-1.
- h = 2^s; j = b mod h; top = (b>>s)·2h + j; bot = top + h.
- Twiddle w = e^(+j2π·j·(N/2h)/N), taken from a constant table.
REQ-018 Butterfly arithmetic SHALL be as follows:
- p = bot·w as a full-precision complex product.
- top' = (top·2^(TW-2) + p + 2^(TW-2)) >>> (TW-1); bot' = (top·2^(TW-2) - p + 2^(TW-2)) >>> (TW-1).
- Each component is saturated to W bits.
- This gives a 1/2 scale per stage and 1/N overall.
REQ-019 Operands SHALL be read combinationally and the results written back on the same edge; no read-after-write stall exists within a stage.
REQ-020 COMPUTE SHALL last exactly log2(N)·N/2 cycles, so out_valid is high after the log2(N)·N/2-th rising edge following the edge that accepted sample N-1 (12 edges for N = 8).
REQ-021 In UNLOAD, out_valid SHALL be 1 and out_re/out_im SHALL present array entry n.
- n advances only on out_valid && out_ready.
- Outputs SHALL be held stable while out_ready is 0.
REQ-022 In LOAD and COMPUTE, out_valid and out_last SHALL be 0 and out_re/out_im SHALL be 0.
REQ-023 A new frame SHALL be acceptable on the cycle after the last output handshake (in_ready = 1), with no idle gap beyond that.
REQ-024 in_valid is ignored outside LOAD, and out_ready is ignored outside UNLOAD.

Reset
REQ-025 rst SHALL, on the next edge and from any state including mid-COMPUTE or mid-UNLOAD:
- force the state to LOAD;
- clear the load, stage, butterfly and output counters to 0;
- set in_ready = 1;
- set out_valid = 0, out_last = 0, busy = 0 and out_re = out_im = 0.
REQ-026 The sample array need not be cleared by reset; the partial frame is discarded.

Structure
REQ-027 Package ifft_pkg SHALL hold the state enum, a bit-reverse function, and the twiddle constant-generation function (cos/sin rounded to Q2.(TW-2)).
REQ-028 Sub-module ifft_bfly SHALL implement the combinational butterfly of REQ-018, parameterised by W and TW; ifft_stream instantiates it once.

Verification
REQ-029 Impulse: N=8, X[0] = (1024,0), other bins 0 -> all eight outputs (128,0), with out_last on n=7.
REQ-030 DC spectrum: all eight bins (1024,0) -> x[0] = (1024,0), x[1..7] = (0,0) within ±1 LSB.
REQ-031 Tone: X[1] = (1024,0), others 0 -> outputs within ±1 LSB of:
- x[0] = (128,0), x[1] = (91,91), x[2] = (0,128), x[4] = (-128,0), x[6] = (0,-128).
REQ-032 Backpressure: out_ready low for 5 cycles on sample n=3 -> out_valid stays 1, out_re/out_im stay unchanged, and no sample is lost or duplicated.
REQ-033 Reset mid-COMPUTE (cycle 6): one edge later -> in_ready = 1, busy = 0, out_valid = 0; a following impulse frame then yields REQ-029 exactly.
REQ-034 Back-to-back: two frames with in_valid held high -> in_ready is 1 on the cycle after frame 1's out_last handshake; latency per REQ-020 is 12 edges.
